// File: rtl/dbus_size_ctl_pkg.sv
// Shared definitions for the data-bus sizing controller: size codes, lane-mux
// replication codes, FSM state encoding and small mask helpers.
package dbus_size_ctl_pkg;

    typedef enum logic [1:0] {
        SZ_8  = 2'd0,
        SZ_16 = 2'd1,
        SZ_32 = 2'd2,
        SZ_64 = 2'd3
    } size_e;

    localparam logic [2:0] DMUXU_8  = 3'b111;
    localparam logic [2:0] DMUXU_16 = 3'b110;
    localparam logic [2:0] DMUXU_32 = 3'b100;
    localparam logic [2:0] DMUXU_64 = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_BUS  = 3'd2,
        ST_NEXT = 3'd3,
        ST_ACK  = 3'd4
    } state_e;

    // Low address bits that must be zero for a naturally aligned transfer.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Bit mask covering the low (1 << chunk) bytes.
    function automatic logic [63:0] byte_mask(input logic [1:0] chunk);
        case (chunk)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/dbus_size_ctl_lane_gen.sv
// Per-beat lane decode: byte enables, lane-mux replication code and the
// right-shift that brings the addressed read lanes down to bit 0.
module dbus_lane_gen
    import dbus_size_ctl_pkg::*;
(
    input  logic [1:0] chunk,
    input  logic [2:0] addr_lo,
    output logic [7:0] bus_be,
    output logic [2:0] dmuxu,
    output logic [5:0] rd_shift
);

    logic [7:0] low_be;

    always_comb begin
        low_be = 8'h01;
        dmuxu  = DMUXU_8;
        case (chunk)
            SZ_8:  begin low_be = 8'h01; dmuxu = DMUXU_8;  end
            SZ_16: begin low_be = 8'h03; dmuxu = DMUXU_16; end
            SZ_32: begin low_be = 8'h0F; dmuxu = DMUXU_32; end
            SZ_64: begin low_be = 8'hFF; dmuxu = DMUXU_64; end
            default: ;
        endcase
    end

    assign bus_be   = low_be << addr_lo;
    assign rd_shift = {addr_lo, 3'b000};

endmodule

// File: rtl/dbus_size_ctl.sv
// Data-bus sizing controller: splits a master transfer into beats no wider
// than the addressed slave port and reassembles read data low-aligned.
module dbus_size_ctl
    import dbus_size_ctl_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          req,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [1:0]    req_size,
    input  logic [63:0]   req_wdata,
    input  logic [1:0]    slv_width,
    output logic          req_ack,
    output logic          req_err,
    output logic [63:0]   rd_data,
    output logic          bus_cyc,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [7:0]    bus_be,
    output logic [63:0]   bus_wdata,
    output logic [2:0]    dmuxu,
    input  logic [63:0]   bus_rdata,
    input  logic          bus_done
);

    state_e        state_reg, state_next;
    logic          write_reg;
    logic [AW-1:0] addr_reg;
    logic [63:0]   wdata_reg;
    logic [1:0]    chunk_reg;
    logic [2:0]    last_beat_reg;
    logic [2:0]    beat_reg;
    logic [63:0]   rd_data_reg;

    logic [1:0]    req_chunk;
    logic [2:0]    req_last_beat;
    logic          misaligned;
    logic [3:0]    cbytes;
    logic [7:0]    lane_be;
    logic [2:0]    lane_dmuxu;
    logic [5:0]    rd_shift;
    logic [63:0]   chunk_mask;
    logic [63:0]   rd_chunk;
    logic [5:0]    rd_offset;
    logic [63:0]   rd_merge;

    assign req_chunk     = (req_size < slv_width) ? req_size : slv_width;
    assign req_last_beat = 3'((4'd1 << (req_size - req_chunk)) - 4'd1);
    assign misaligned    = |(req_addr[2:0] & align_mask(req_size));
    assign cbytes        = 4'd1 << chunk_reg;

    dbus_lane_gen u_lane_gen (
        .chunk    (chunk_reg),
        .addr_lo  (addr_reg[2:0]),
        .bus_be   (lane_be),
        .dmuxu    (lane_dmuxu),
        .rd_shift (rd_shift)
    );

    // Beat n of a read lands at byte offset n * cbytes of the assembled word.
    assign chunk_mask = byte_mask(chunk_reg);
    assign rd_chunk   = (bus_rdata >> rd_shift) & chunk_mask;
    assign rd_offset  = 6'({beat_reg, 3'b000} << chunk_reg);
    assign rd_merge   = (rd_data_reg & ~(chunk_mask << rd_offset)) | (rd_chunk << rd_offset);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (req) state_next = misaligned ? ST_ERR : ST_BUS;
            ST_ERR:  state_next = ST_IDLE;
            ST_BUS:  if (bus_done) state_next = (beat_reg == last_beat_reg) ? ST_ACK : ST_NEXT;
            ST_NEXT: state_next = ST_BUS;
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            chunk_reg     <= '0;
            last_beat_reg <= '0;
            beat_reg      <= '0;
            rd_data_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        write_reg     <= req_write;
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        chunk_reg     <= req_chunk;
                        last_beat_reg <= req_last_beat;
                        beat_reg      <= '0;
                        rd_data_reg   <= '0;
                    end
                end
                ST_BUS: begin
                    if (bus_done) rd_data_reg <= rd_merge;
                end
                ST_NEXT: begin
                    addr_reg  <= addr_reg + AW'(cbytes);
                    wdata_reg <= wdata_reg >> {cbytes, 3'b000};
                    beat_reg  <= beat_reg + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Lane controls are only meaningful while a bus cycle is open.
    assign bus_cyc   = (state_reg == ST_BUS);
    assign bus_we    = bus_cyc & write_reg;
    assign bus_be    = bus_cyc ? lane_be : 8'h00;
    assign dmuxu     = bus_cyc ? lane_dmuxu : 3'b000;
    assign bus_addr  = addr_reg;
    assign bus_wdata = wdata_reg;
    assign req_ack   = (state_reg == ST_ACK) || (state_reg == ST_ERR);
    assign req_err   = (state_reg == ST_ERR);
    assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_dbus_size_ctl.sv
// Scoreboard bench for dbus_size_ctl: expected beats and acks are queued by the
// stimulus and checked by a monitor whenever the DUT completes a beat or acks.
module tb_dbus_size_ctl;

    localparam int AW = 24;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [1:0]    req_size = 2'd0;
    logic [63:0]   req_wdata = '0;
    logic [1:0]    slv_width = 2'd0;
    logic [63:0]   bus_rdata = '0;
    logic          bus_done = 1'b0;
    logic          req_ack, req_err, bus_cyc, bus_we;
    logic [63:0]   rd_data, bus_wdata;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_be;
    logic [2:0]    dmuxu;

    dbus_size_ctl #(.AW(AW)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .slv_width (slv_width),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .rd_data   (rd_data),
        .bus_cyc   (bus_cyc),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .dmuxu     (dmuxu),
        .bus_rdata (bus_rdata),
        .bus_done  (bus_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    be;
        logic [2:0]    dmuxu;
        logic          we;
        logic [63:0]   wdata;
        logic [63:0]   wmask;
    } beat_t;

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [63:0] rd;
    } ack_t;

    beat_t       exp_beats[$];
    ack_t        exp_acks[$];
    beat_t       eb;
    ack_t        ea;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [63:0] lanes[8];
    bit          done_in_next = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_beat(input logic [AW-1:0] a, input logic [7:0] be, input logic [2:0] dm,
                             input logic we, input logic [63:0] wd, input logic [63:0] wm);
        beat_t b;
        b.addr = a; b.be = be; b.dmuxu = dm; b.we = we; b.wdata = wd; b.wmask = wm;
        exp_beats.push_back(b);
    endtask

    task automatic push_ack(input logic err, input logic chk, input logic [63:0] rd);
        ack_t a;
        a.err = err; a.chk_rd = chk; a.rd = rd;
        exp_acks.push_back(a);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_cyc(input string name);
        int t = 0;
        while (!bus_cyc && t < 20) begin
            tick();
            t++;
        end
        if (!bus_cyc) begin
            n_checks++;
            $display("FAIL %s: bus_cyc got 0 expected 1 within 20 cycles", name);
        end
    endtask

    // Monitor: beat completion and ack are compared against queued expectations.
    always @(negedge sys_clk) begin
        if (!reset) begin
            if (bus_cyc && bus_done) begin
                if (exp_beats.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got addr %h expected none", bus_addr);
                end else begin
                    eb = exp_beats.pop_front();
                    check("beat_addr", 64'(bus_addr), 64'(eb.addr));
                    check("beat_be", 64'(bus_be), 64'(eb.be));
                    check("beat_dmuxu", 64'(dmuxu), 64'(eb.dmuxu));
                    check("beat_we", 64'(bus_we), 64'(eb.we));
                    if (eb.wmask != 64'h0)
                        check("beat_wdata", bus_wdata & eb.wmask, eb.wdata);
                end
            end
            if (req_ack) begin
                if (exp_acks.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ack: got err %0b expected no ack", req_err);
                end else begin
                    ea = exp_acks.pop_front();
                    check("ack_err", 64'(req_err), 64'(ea.err));
                    if (ea.chk_rd) check("rd_data", rd_data, ea.rd);
                end
            end
        end
    end

    // Drives one transfer and plays slave for nb beats (nb=0 means rejection expected).
    task automatic xfer(input string name, input logic wr, input logic [AW-1:0] a,
                        input logic [1:0] sz, input logic [63:0] wd, input logic [1:0] w,
                        input int nb);
        req = 1'b1; req_write = wr; req_addr = a; req_size = sz; req_wdata = wd; slv_width = w;
        tick();
        req = 1'b0;
        for (int b = 0; b < nb; b++) begin
            wait_cyc(name);
            bus_rdata = lanes[b];
            bus_done = 1'b1;
            tick();
            if (b < nb - 1) begin
                if (done_in_next) bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
                else bus_done = 1'b0;
                check({name, "_gap"}, 64'(bus_cyc), 64'd0);
                tick();
                bus_done = 1'b0;
                check({name, "_rebus"}, 64'(bus_cyc), 64'd1);
            end
            bus_done = 1'b0;
        end
        check({name, "_ack_lat"}, 64'(req_ack), 64'd1);
        if (nb == 0) check({name, "_no_cyc"}, 64'(bus_cyc), 64'd0);
        tick();
        check({name, "_ack_pulse"}, 64'(req_ack), 64'd0);
        if (nb == 0) check({name, "_no_cyc2"}, 64'(bus_cyc), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) lanes[i] = '0;
        repeat (3) tick();
        check("rst_cyc", 64'(bus_cyc), 64'd0);
        check("rst_ack", 64'(req_ack), 64'd0);
        check("rst_err", 64'(req_err), 64'd0);
        check("rst_rd", rd_data, 64'd0);
        check("rst_be", 64'(bus_be), 64'd0);
        check("rst_dmuxu", 64'(dmuxu), 64'd0);
        check("rst_addr", 64'(bus_addr), 64'd0);
        check("rst_wdata", bus_wdata, 64'd0);
        check("rst_we", 64'(bus_we), 64'd0);
        reset = 1'b0;
        tick();

        // 32b write into a 32b port: single beat in the upper half of the word
        push_beat(24'h000104, 8'hF0, 3'b100, 1'b1, 64'h11223344, 64'hFFFF_FFFF);
        push_ack(1'b0, 1'b0, 64'h0);
        xfer("t1", 1'b1, 24'h000104, 2'd2, 64'h11223344, 2'd2, 1);

        // 32b write into an 8b port: four byte beats
        push_beat(24'h000100, 8'h01, 3'b111, 1'b1, 64'h44, 64'hFF);
        push_beat(24'h000101, 8'h02, 3'b111, 1'b1, 64'h33, 64'hFF);
        push_beat(24'h000102, 8'h04, 3'b111, 1'b1, 64'h22, 64'hFF);
        push_beat(24'h000103, 8'h08, 3'b111, 1'b1, 64'h11, 64'hFF);
        push_ack(1'b0, 1'b0, 64'h0);
        xfer("t2", 1'b1, 24'h000100, 2'd2, 64'h11223344, 2'd0, 4);

        // 64b read from a 16b port, junk on unused lanes, bus_done held through NEXT
        lanes[0] = 64'hDEAD_BEEF_CAFE_1111;
        lanes[1] = 64'hAAAA_BBBB_2222_CCCC;
        lanes[2] = 64'h5555_3333_6666_7777;
        lanes[3] = 64'h4444_9999_8888_7777;
        push_beat(24'h000200, 8'h03, 3'b110, 1'b0, 64'h0, 64'h0);
        push_beat(24'h000202, 8'h0C, 3'b110, 1'b0, 64'h0, 64'h0);
        push_beat(24'h000204, 8'h30, 3'b110, 1'b0, 64'h0, 64'h0);
        push_beat(24'h000206, 8'hC0, 3'b110, 1'b0, 64'h0, 64'h0);
        push_ack(1'b0, 1'b1, 64'h4444_3333_2222_1111);
        done_in_next = 1'b1;
        xfer("t3", 1'b0, 24'h000200, 2'd3, 64'h0, 2'd1, 4);
        done_in_next = 1'b0;

        // 64b read from a 64b port: full-width single beat
        lanes[0] = 64'h0123_4567_89AB_CDEF;
        push_beat(24'h000208, 8'hFF, 3'b000, 1'b0, 64'h0, 64'h0);
        push_ack(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
        xfer("t3b", 1'b0, 24'h000208, 2'd3, 64'h0, 2'd3, 1);

        // misaligned 16b write is rejected with no bus cycle
        push_ack(1'b1, 1'b0, 64'h0);
        xfer("t4", 1'b1, 24'h000101, 2'd1, 64'hBEEF, 2'd3, 0);

        // bus_done in IDLE is ignored
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        check("t6_idle_done_cyc", 64'(bus_cyc), 64'd0);
        check("t6_idle_done_ack", 64'(req_ack), 64'd0);

        // reset during the second beat of a byte-split write
        push_beat(24'h000100, 8'h01, 3'b111, 1'b1, 64'h44, 64'hFF);
        req = 1'b1; req_write = 1'b1; req_addr = 24'h000100; req_size = 2'd2;
        req_wdata = 64'h11223344; slv_width = 2'd0;
        tick();
        req = 1'b0;
        wait_cyc("t5");
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        tick();
        check("t5_beat2_cyc", 64'(bus_cyc), 64'd1);
        check("t5_beat2_addr", 64'(bus_addr), 64'h000101);
        #2 reset = 1'b1;
        #1 check("t5_async_drop", 64'(bus_cyc), 64'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5_no_ack", 64'(req_ack), 64'd0);
            check("t5_no_cyc", 64'(bus_cyc), 64'd0);
            tick();
        end
        check("t5_queue_beats", 64'(exp_beats.size()), 64'd0);
        check("t5_queue_acks", 64'(exp_acks.size()), 64'd0);
        push_beat(24'h000000, 8'h01, 3'b111, 1'b1, 64'hA5, 64'hFF);
        push_ack(1'b0, 1'b0, 64'h0);
        xfer("t5_after", 1'b1, 24'h000000, 2'd0, 64'hA5, 2'd0, 1);

        // req held high through ACK: re-accepted only in the following IDLE cycle
        push_beat(24'h000010, 8'h01, 3'b111, 1'b1, 64'h5A, 64'hFF);
        push_beat(24'h000010, 8'h01, 3'b111, 1'b1, 64'h5A, 64'hFF);
        push_ack(1'b0, 1'b0, 64'h0);
        push_ack(1'b0, 1'b0, 64'h0);
        req = 1'b1; req_write = 1'b1; req_addr = 24'h000010; req_size = 2'd0;
        req_wdata = 64'h5A; slv_width = 2'd0;
        tick();
        check("t6_first_cyc", 64'(bus_cyc), 64'd1);
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        check("t6_first_ack", 64'(req_ack), 64'd1);
        check("t6_ack_nocyc", 64'(bus_cyc), 64'd0);
        tick();
        check("t6_idle_cyc", 64'(bus_cyc), 64'd0);
        check("t6_idle_ack", 64'(req_ack), 64'd0);
        tick();
        req = 1'b0;
        check("t6_second_cyc", 64'(bus_cyc), 64'd1);
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        check("t6_second_ack", 64'(req_ack), 64'd1);
        tick();
        tick();

        check("end_queue_beats", 64'(exp_beats.size()), 64'd0);
        check("end_queue_acks", 64'(exp_acks.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
